hub75_bcm_sched: RTL and testbench

- Row/bit-plane scheduler for the HUB75 shifter.
- Walks every (row, plane) pair of a frame and launches one column shift per pair through the shifter's go/rdy handshake.
- Once a shift has fully drained, blanks the panel, drives the row address, pulses latch, then unblanks for a binary-weighted (BCM) on-time.
- Shifting of the next plane overlaps the on-time of the current plane.

---
 rtl/hub75_bcm_sched.sv | 178 +++++++++++++++++
 tb/tb_hub75_bcm_sched.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hub75_bcm_sched.sv
// HUB75 row/bit-plane scheduler.
// Walks every (row, plane) pair, launches one column shift per pair, then
// blanks, drives the row address, latches and unblanks for a BCM on-time.
// The shift of the next pair overlaps the on-time of the current one.
module hub75_bcm_sched #(
    parameter int N_ROWS      = 32,
    parameter int N_PLANES    = 8,
    parameter int BCM_LSB_LEN = 16,
    parameter int BLANK_CYC   = 4,
    parameter int LATCH_CYC   = 2,
    parameter int LOG_N_ROWS  = $clog2(N_ROWS),
    parameter int TW          = $clog2(BCM_LSB_LEN << (N_PLANES - 1)) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ctrl_run,
    output logic                  shift_go,
    input  logic                  shift_rdy,
    output logic [N_PLANES-1:0]   shift_plane,
    output logic [LOG_N_ROWS-1:0] shift_addr,
    output logic [LOG_N_ROWS-1:0] phy_addr,
    output logic                  phy_le,
    output logic                  phy_blank,
    output logic                  frame_end
);

    localparam int DRAIN_CYC = 3;
    localparam int CMAX = (BLANK_CYC > LATCH_CYC)
                        ? ((BLANK_CYC > DRAIN_CYC) ? BLANK_CYC : DRAIN_CYC)
                        : ((LATCH_CYC > DRAIN_CYC) ? LATCH_CYC : DRAIN_CYC);
    localparam int CW = $clog2(CMAX + 1);
    localparam int PW = (N_PLANES > 1) ? $clog2(N_PLANES) : 1;

    localparam logic [CW-1:0]         C_ONE      = CW'(1);
    localparam logic [CW-1:0]         DRAIN_LAST = CW'(DRAIN_CYC - 1);
    localparam logic [CW-1:0]         BLANK_LAST = CW'(BLANK_CYC - 1);
    localparam logic [CW-1:0]         LATCH_LAST = CW'(LATCH_CYC - 1);
    localparam logic [PW-1:0]         P_ONE      = PW'(1);
    localparam logic [PW-1:0]         P_LAST     = PW'(N_PLANES - 1);
    localparam logic [LOG_N_ROWS-1:0] R_ONE      = LOG_N_ROWS'(1);
    localparam logic [LOG_N_ROWS-1:0] R_LAST     = LOG_N_ROWS'(N_ROWS - 1);
    localparam logic [TW-1:0]         T_ONE      = TW'(1);
    localparam logic [TW-1:0]         LSB_T      = TW'(BCM_LSB_LEN);
    localparam logic [N_PLANES-1:0]   PLANE1     = N_PLANES'(1);

    typedef enum logic [3:0] {
        IDLE,
        SHIFT_GO,
        SHIFT_WAIT,
        DRAIN,
        WAIT_DISP,
        BLANK,
        LATCH,
        NEXT,
        STOP
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [PW-1:0]   p;
    logic [TW-1:0]   timer;

    // Scheduler FSM, on-time timer and all registered outputs.
    // shift_addr doubles as the row counter; the timer runs in every state
    // and the LATCH exit reload is placed after it so the reload wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            p           <= '0;
            timer       <= '0;
            shift_go    <= 1'b0;
            shift_plane <= PLANE1;
            shift_addr  <= '0;
            phy_addr    <= '0;
            phy_le      <= 1'b0;
            phy_blank   <= 1'b1;
            frame_end   <= 1'b0;
        end else begin
            shift_go  <= 1'b0;
            frame_end <= 1'b0;

            if (timer != '0) begin
                timer <= timer - T_ONE;
                if (timer == T_ONE) begin
                    phy_blank <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (ctrl_run) begin
                        p           <= '0;
                        shift_addr  <= '0;
                        shift_plane <= PLANE1;
                        state       <= SHIFT_GO;
                    end
                end
                SHIFT_GO: begin
                    if (shift_rdy) begin
                        shift_go <= 1'b1;
                        cnt      <= '0;
                        state    <= SHIFT_WAIT;
                    end
                end
                SHIFT_WAIT: begin
                    if (cnt == '0) begin
                        cnt <= C_ONE;
                    end else if (shift_rdy) begin
                        cnt   <= '0;
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (cnt == DRAIN_LAST) begin
                        cnt   <= '0;
                        state <= WAIT_DISP;
                    end else begin
                        cnt <= cnt + C_ONE;
                    end
                end
                WAIT_DISP: begin
                    if (timer == '0) begin
                        cnt   <= '0;
                        state <= BLANK;
                    end
                end
                BLANK: begin
                    phy_blank <= 1'b1;
                    if (cnt == '0) begin
                        phy_addr <= shift_addr;
                    end
                    if (cnt == BLANK_LAST) begin
                        cnt    <= '0;
                        phy_le <= 1'b1;
                        state  <= LATCH;
                    end else begin
                        cnt <= cnt + C_ONE;
                    end
                end
                LATCH: begin
                    if (cnt == LATCH_LAST) begin
                        cnt       <= '0;
                        phy_le    <= 1'b0;
                        timer     <= LSB_T << p;
                        phy_blank <= 1'b0;
                        state     <= NEXT;
                    end else begin
                        cnt <= cnt + C_ONE;
                    end
                end
                NEXT: begin
                    if (p == P_LAST) begin
                        p           <= '0;
                        shift_plane <= PLANE1;
                        if (shift_addr == R_LAST) begin
                            shift_addr <= '0;
                            frame_end  <= 1'b1;
                        end else begin
                            shift_addr <= shift_addr + R_ONE;
                        end
                    end else begin
                        p           <= p + P_ONE;
                        shift_plane <= shift_plane << 1;
                    end
                    state <= ctrl_run ? SHIFT_GO : STOP;
                end
                STOP: begin
                    if (timer == '0) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hub75_bcm_sched.sv
// Scoreboard bench for hub75_bcm_sched.
// Instance A uses default parameters with a 64-cycle shifter model.
// Instance B uses BCM_LSB_LEN=1 with an 8-cycle shifter to cover a full frame.
module tb_hub75_bcm_sched;

    typedef struct packed {
        logic [4:0] addr;
        logic [7:0] plane;
    } latch_t;

    logic clk;
    int   total = 0;
    int   bad   = 0;

    // instance A signals
    logic       rst_n, ctrl_run, shift_rdy;
    logic       shift_go, phy_le, phy_blank, frame_end;
    logic [7:0] shift_plane;
    logic [4:0] shift_addr, phy_addr;

    // instance B signals
    logic       rst_b_n, run_b, rdy_b;
    logic       go_b, le_b, blank_b, fe_b;
    logic [7:0] plane_b;
    logic [4:0] saddr_b, paddr_b;

    latch_t exp_la[$];
    int     exp_on[$];
    latch_t exp_lb[$];

    int cyc_a = 0, go_a = 0, latch_a = 0, on_a = 0, low_a = 0, rdy_rise_a = 0;
    int cyc_b = 0, latch_b = 0, last_le_b = 0, fe_cnt_b = 0;
    logic b_done = 1'b0;

    hub75_bcm_sched dut_a (
        .clk(clk), .rst_n(rst_n), .ctrl_run(ctrl_run),
        .shift_go(shift_go), .shift_rdy(shift_rdy),
        .shift_plane(shift_plane), .shift_addr(shift_addr),
        .phy_addr(phy_addr), .phy_le(phy_le), .phy_blank(phy_blank),
        .frame_end(frame_end)
    );

    hub75_bcm_sched #(
        .N_ROWS(32), .N_PLANES(8), .BCM_LSB_LEN(1), .BLANK_CYC(4), .LATCH_CYC(2)
    ) dut_b (
        .clk(clk), .rst_n(rst_b_n), .ctrl_run(run_b),
        .shift_go(go_b), .shift_rdy(rdy_b),
        .shift_plane(plane_b), .shift_addr(saddr_b),
        .phy_addr(paddr_b), .phy_le(le_b), .phy_blank(blank_b),
        .frame_end(fe_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Shifter model A: rdy drops after go and stays low for 64 cycles.
    initial begin
        int busy;
        busy = 0;
        shift_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (!rst_n) begin
                busy = 0;
                shift_rdy = 1'b1;
            end else if (shift_go) begin
                busy = 64;
                shift_rdy = 1'b0;
            end else if (busy > 0) begin
                busy--;
                shift_rdy = (busy == 0);
            end
        end
    end

    // Shifter model B: 8-cycle shift.
    initial begin
        int busy;
        busy = 0;
        rdy_b = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (!rst_b_n) begin
                busy = 0;
                rdy_b = 1'b1;
            end else if (go_b) begin
                busy = 8;
                rdy_b = 1'b0;
            end else if (busy > 0) begin
                busy--;
                rdy_b = (busy == 0);
            end
        end
    end

    // Monitor A: latches, on-times and blank ordering.
    initial begin
        logic prev_le, prev_blank, prev_rdy;
        latch_t e;
        int t;
        prev_le = 1'b0; prev_blank = 1'b1; prev_rdy = 1'b1;
        forever begin
            @(negedge clk);
            cyc_a++;
            if (!rst_n) begin
                prev_le = 1'b0; prev_blank = 1'b1; prev_rdy = 1'b1; low_a = 0;
            end else begin
                if (shift_go) go_a++;
                if (shift_rdy && !prev_rdy) rdy_rise_a = cyc_a;
                if (phy_le && !prev_le) begin
                    latch_a++;
                    if (latch_a == 1) begin
                        chk("go_once_before_latch", go_a, 1);
                        chk("le_after_rdy", cyc_a - rdy_rise_a, 9);
                    end
                    if (exp_la.size() == 0) begin
                        total++; bad++;
                        $display("FAIL latch_unexpected: got addr %0d plane %0h expected none", phy_addr, shift_plane);
                    end else begin
                        e = exp_la.pop_front();
                        chk("latch_addr", phy_addr, e.addr);
                        chk("latch_plane", shift_plane, e.plane);
                    end
                end
                if (!phy_blank && prev_blank) chk("unblank_after_latch", prev_le, 1);
                if (!phy_blank) low_a++;
                if (phy_blank && !prev_blank) begin
                    on_a++;
                    if (exp_on.size() == 0) begin
                        total++; bad++;
                        $display("FAIL on_unexpected: got %0d cycles expected none", low_a);
                    end else begin
                        t = exp_on.pop_front();
                        chk("on_time", low_a, t);
                    end
                    low_a = 0;
                end
                prev_le = phy_le; prev_blank = phy_blank; prev_rdy = shift_rdy;
            end
        end
    end

    // Monitor B: latch order across a frame and frame_end timing.
    initial begin
        logic prev_le, prev_fe;
        latch_t e;
        prev_le = 1'b0; prev_fe = 1'b0;
        forever begin
            @(negedge clk);
            cyc_b++;
            if (rst_b_n) begin
                if (le_b && !prev_le) begin
                    latch_b++;
                    last_le_b = cyc_b;
                    if (exp_lb.size() == 0) begin
                        total++; bad++;
                        $display("FAIL b_latch_unexpected: got addr %0d plane %0h expected none", paddr_b, plane_b);
                    end else begin
                        e = exp_lb.pop_front();
                        chk("b_latch_addr", paddr_b, e.addr);
                        chk("b_latch_plane", plane_b, e.plane);
                    end
                end
                if (prev_fe) chk("fe_width", fe_b, 0);
                if (fe_b && !prev_fe) begin
                    fe_cnt_b++;
                    chk("fe_latch_count", latch_b, 256);
                    chk("fe_delay", cyc_b - last_le_b, 3);
                end
                prev_le = le_b; prev_fe = fe_b;
            end
        end
    end

    // Stimulus B: one full frame plus four pairs, then stop.
    initial begin
        int n;
        rst_b_n = 1'b0;
        run_b = 1'b0;
        for (int r = 0; r < 32; r++)
            for (int p = 0; p < 8; p++)
                exp_lb.push_back('{addr: 5'(r), plane: 8'(1 << p)});
        for (int p = 0; p < 4; p++)
            exp_lb.push_back('{addr: 5'd0, plane: 8'(1 << p)});
        repeat (3) @(negedge clk);
        rst_b_n = 1'b1;
        run_b = 1'b1;
        n = 0;
        while (latch_b < 260 && n < 40000) begin
            @(negedge clk); #1; n++;
        end
        chk("b_reach_260", latch_b, 260);
        run_b = 1'b0;
        repeat (400) @(negedge clk);
        b_done = 1'b1;
    end

    // Stimulus A and final checks.
    initial begin
        int n, go_drop;
        rst_n = 1'b0;
        ctrl_run = 1'b0;
        for (int r = 0; r < 6; r++)
            for (int p = 0; p < 8; p++)
                if (r < 5 || p < 4) begin
                    exp_la.push_back('{addr: 5'(r), plane: 8'(1 << p)});
                    exp_on.push_back(16 << p);
                end
        exp_la.push_back('{addr: 5'd0, plane: 8'h01});

        repeat (3) @(negedge clk);
        chk("rst_shift_go", shift_go, 0);
        chk("rst_shift_plane", shift_plane, 8'h01);
        chk("rst_shift_addr", shift_addr, 0);
        chk("rst_phy_addr", phy_addr, 0);
        chk("rst_phy_le", phy_le, 0);
        chk("rst_phy_blank", phy_blank, 1);
        chk("rst_frame_end", frame_end, 0);

        rst_n = 1'b1;
        ctrl_run = 1'b1;

        n = 0;
        while (latch_a < 44 && n < 40000) begin
            @(negedge clk); #1; n++;
        end
        chk("reach_latch_r5p3", latch_a, 44);
        ctrl_run = 1'b0;
        go_drop = go_a;
        chk("go_count_at_drop", go_a, 44);

        n = 0;
        while (on_a < 44 && n < 2000) begin
            @(negedge clk); #1; n++;
        end
        chk("reach_last_on", on_a, 44);
        repeat (20) @(negedge clk);
        #1;
        chk("no_go_after_drop", go_a, go_drop);
        chk("idle_blank", phy_blank, 1);
        chk("idle_le", phy_le, 0);

        n = 0;
        while (!b_done && n < 40000) begin
            @(negedge clk); #1; n++;
        end
        chk("b_done", b_done, 1);

        ctrl_run = 1'b1;
        n = 0;
        while (go_a == go_drop && n < 20) begin
            @(negedge clk); #1; n++;
        end
        chk("restart_go", go_a, go_drop + 1);
        chk("restart_addr", shift_addr, 0);
        chk("restart_plane", shift_plane, 8'h01);

        n = 0;
        while (latch_a < 45 && n < 300) begin
            @(negedge clk); #1; n++;
        end
        chk("reach_restart_latch", latch_a, 45);
        chk("in_latch_le", phy_le, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_phy_le", phy_le, 0);
        chk("arst_phy_blank", phy_blank, 1);
        chk("arst_shift_go", shift_go, 0);
        chk("arst_shift_plane", shift_plane, 8'h01);
        chk("arst_shift_addr", shift_addr, 0);
        chk("arst_phy_addr", phy_addr, 0);
        chk("arst_frame_end", frame_end, 0);
        ctrl_run = 1'b0;
        repeat (3) @(negedge clk);

        chk("a_latch_queue_left", exp_la.size(), 0);
        chk("a_on_queue_left", exp_on.size(), 0);
        chk("b_latch_queue_left", exp_lb.size(), 0);
        chk("b_frame_end_count", fe_cnt_b, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
